// File: rtl/handshake_master.sv
// handshake_master
//   Source side of a valid/ready handshake. A local producer pushes words
//   into a small FIFO; an output register presents them to the slave with
//   valid held until acceptance and data stable while waiting. Counts
//   completed transfers.
//
//   State table:
//     IDLE | output register empty, valid=0; loads the FIFO head when available
//     SEND | output register holds a word, valid=1; waits for ready
//
// Ports:
//   clk       system clock, all state on posedge
//   rst       asynchronous active-high reset
//   wr_en     producer write strobe (ignored while full)
//   wr_data   producer word
//   full      FIFO holds DEPTH entries
//   fifo_cnt  FIFO occupancy 0..DEPTH (output register not included)
//   valid     handshake valid (registered)
//   data      handshake data (registered)
//   ready     handshake ready from the slave, sampled at posedge
//   busy      valid=1 or FIFO non-empty
//   xfer_cnt  completed transfers, wraps
module handshake_master #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     valid,
    output logic [DATA_W-1:0]        data,
    input  logic                     ready,
    output logic                     busy,
    output logic [CNT_W-1:0]         xfer_cnt
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    L_FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [AW:0]         r_cnt;
    logic                r_valid;
    logic [DATA_W-1:0]   r_data;
    logic [CNT_W-1:0]    r_xfer_cnt;

    logic                w_push;
    logic                w_pop;
    logic                w_xfer;
    logic                w_valid_nxt;
    logic [DATA_W-1:0]   w_data_nxt;
    logic [AW:0]         w_cnt_nxt;

    assign full     = (r_cnt == L_FULL_CNT);
    assign fifo_cnt = r_cnt;
    assign valid    = r_valid;
    assign data     = r_data;
    assign busy     = r_valid || (r_cnt != '0);
    assign xfer_cnt = r_xfer_cnt;

    // A write while full is dropped, so a pop and an accepted write never
    // target the same slot in the same edge.
    assign w_push    = wr_en && !full;
    assign w_cnt_nxt = r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_valid;
        w_data_nxt  = r_data;
        w_pop       = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_cnt != '0) begin
                    w_pop       = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_data_nxt  = r_mem[r_rptr];
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ready) begin
                    w_xfer = 1'b1;
                    if (r_cnt != '0) begin
                        // back-to-back: reload output register in the transfer edge
                        w_pop      = 1'b1;
                        w_data_nxt = r_mem[r_rptr];
                    end else begin
                        w_valid_nxt = 1'b0;
                        w_data_nxt  = '0;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_valid_nxt = 1'b0;
                w_data_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_valid    <= 1'b0;
            r_data     <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_cnt      <= '0;
            r_xfer_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_valid <= w_valid_nxt;
            r_data  <= w_data_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_xfer) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_W'(1);
            end
        end
    end

    // Storage needs no reset; occupancy and pointers define what is live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_handshake_master.sv
module tb_handshake_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        full;
    logic [2:0]  fifo_cnt;
    logic        valid;
    logic [31:0] data;
    logic        ready = 1'b0;
    logic        busy;
    logic [15:0] xfer_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    logic [15:0] exp_x = '0;
    logic        mon_v = 1'b0;
    logic [31:0] mon_d = '0;
    logic        hold_chk = 1'b0;
    logic [31:0] hold_d = '0;
    logic        slave_en = 1'b0;

    always #5 clk = ~clk;

    handshake_master #(.DATA_W(32), .DEPTH(4), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .fifo_cnt (fifo_cnt),
        .valid    (valid),
        .data     (data),
        .ready    (ready),
        .busy     (busy),
        .xfer_cnt (xfer_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: a transfer is valid=1 and ready=1 at a posedge.
    always @(negedge clk) begin
        if (hold_chk) begin
            chk("hold_valid", 64'(valid), 64'd1);
            chk("hold_data", 64'(data), 64'(hold_d));
            hold_chk = 1'b0;
        end
        mon_v = valid;
        mon_d = data;
    end

    always @(posedge clk) begin
        if (rst) begin
            hold_chk = 1'b0;
        end else if (mon_v) begin
            if (ready) begin
                chk("xfer_expected", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    chk("xfer_data", 64'(mon_d), 64'(q.pop_front()));
                end
                exp_x = exp_x + 16'd1;
            end else begin
                hold_chk = 1'b1;
                hold_d   = mon_d;
            end
        end
    end

    // Slave that raises ready on the negedge after valid, with random stalls.
    always @(negedge clk) begin
        if (slave_en) begin
            ready = valid && ($urandom_range(0, 3) != 0);
        end
    end

    task automatic write_word(input logic [31:0] d, input bit accept);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_data = d;
        if (accept) q.push_back(d);
    endtask

    task automatic write_fc(input logic [31:0] d);
        int n = 0;
        @(negedge clk);
        while (full && n < 50) begin
            wr_en = 1'b0;
            @(negedge clk);
            n++;
        end
        if (full) begin
            chk("wr_full_timeout", 64'(full), 64'd0);
            wr_en = 1'b0;
        end else begin
            wr_en   = 1'b1;
            wr_data = d;
            q.push_back(d);
        end
    endtask

    task automatic end_wr();
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(busy), 64'd0);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_data", 64'(data), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 1: basic single word, ready tied high
        ready = 1'b1;
        write_word(32'hA5A5_0001, 1'b1);
        end_wr();
        chk("t1_valid_after_write", 64'(valid), 64'd0);
        chk("t1_cnt_after_write", 64'(fifo_cnt), 64'd1);
        @(negedge clk);
        chk("t1_valid_after_pop", 64'(valid), 64'd1);
        chk("t1_data_after_pop", 64'(data), 64'hA5A5_0001);
        chk("t1_cnt_after_pop", 64'(fifo_cnt), 64'd0);
        @(negedge clk);
        chk("t1_valid_after_xfer", 64'(valid), 64'd0);
        chk("t1_busy_after_xfer", 64'(busy), 64'd0);
        chk("t1_xfer_cnt", 64'(xfer_cnt), 64'(exp_x));
        chk("t1_xfer_cnt_abs", 64'(xfer_cnt), 64'd1);

        // 2: backpressure
        ready = 1'b0;
        write_word(32'h11, 1'b1);
        write_word(32'h22, 1'b1);
        write_word(32'h33, 1'b1);
        end_wr();
        repeat (10) @(negedge clk);
        chk("t2_valid_held", 64'(valid), 64'd1);
        chk("t2_data_held", 64'(data), 64'h11);
        chk("t2_fifo_cnt", 64'(fifo_cnt), 64'd2);
        ready = 1'b1;
        @(negedge clk);
        chk("t2_data_b2b_1", 64'(data), 64'h22);
        @(negedge clk);
        chk("t2_data_b2b_2", 64'(data), 64'h33);
        @(negedge clk);
        chk("t2_valid_done", 64'(valid), 64'd0);
        chk("t2_xfer_cnt", 64'(xfer_cnt), 64'd4);

        // 3: fill FIFO plus output register, sixth word dropped
        ready = 1'b0;
        for (int i = 1; i <= 5; i++) write_word(32'(i), 1'b1);
        write_word(32'd6, 1'b0);
        end_wr();
        chk("t3_full", 64'(full), 64'd1);
        chk("t3_fifo_cnt", 64'(fifo_cnt), 64'd4);
        chk("t3_data_head", 64'(data), 64'd1);
        chk("t3_valid", 64'(valid), 64'd1);
        repeat (3) @(negedge clk);
        chk("t3_full_after_drop", 64'(fifo_cnt), 64'd4);
        ready = 1'b1;
        drain(50);
        chk("t3_xfer_cnt", 64'(xfer_cnt), 64'(exp_x));
        chk("t3_xfer_cnt_abs", 64'(xfer_cnt), 64'd9);
        chk("t3_q_empty", 64'(q.size()), 64'd0);

        // 4: simultaneous push/pop at fifo_cnt=2
        ready = 1'b0;
        for (int i = 0; i < 3; i++) write_word(32'h400 + 32'(i), 1'b1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t4_fifo_cnt", 64'(fifo_cnt), 64'd2);
            ready   = 1'b1;
            wr_en   = 1'b1;
            wr_data = 32'h403 + 32'(i);
            q.push_back(wr_data);
        end
        end_wr();
        chk("t4_fifo_cnt_end", 64'(fifo_cnt), 64'd2);
        drain(50);
        chk("t4_xfer_cnt", 64'(xfer_cnt), 64'd20);

        // 5: negedge-driven slave with stalls
        slave_en = 1'b1;
        for (int i = 0; i < 16; i++) write_fc(32'h100 + 32'(i));
        end_wr();
        drain(400);
        slave_en = 1'b0;
        ready = 1'b0;
        chk("t5_xfer_cnt", 64'(xfer_cnt), 64'(exp_x));
        chk("t5_xfer_cnt_abs", 64'(xfer_cnt), 64'd36);
        chk("t5_q_empty", 64'(q.size()), 64'd0);

        // 6: asynchronous reset mid-burst
        for (int i = 0; i < 4; i++) write_word(32'h600 + 32'(i), 1'b1);
        end_wr();
        chk("t6_pre_valid", 64'(valid), 64'd1);
        chk("t6_pre_fifo_cnt", 64'(fifo_cnt), 64'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(valid), 64'd0);
        chk("t6_rst_data", 64'(data), 64'd0);
        chk("t6_rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
        chk("t6_rst_xfer_cnt", 64'(xfer_cnt), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        q.delete();
        exp_x = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ready = 1'b1;
        write_word(32'hDEAD_BEEF, 1'b1);
        end_wr();
        @(negedge clk);
        chk("t6_first_word", 64'(data), 64'hDEAD_BEEF);
        drain(20);
        chk("t6_xfer_cnt", 64'(xfer_cnt), 64'd1);
        chk("t6_q_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
